sysid_check_master: RTL and testbench

- Avalon-MM master that sits directly downstream of the system-ID slave and consumes its readdata.
- After a start request it reads word 0 (system ID) and word 1 (build timestamp) and compares both against build-time expected values.
- Publishes pass, fail and timeout status for boot logic and the quadrature-decoder test control.
- Retries bus reads that stall; never retries a data mismatch.

---
 rtl/sysid_check_master.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_sysid_check_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// -----------------------------------------------------------------------------
// sysid_check_master
//
// Avalon-MM read master placed directly downstream of the system-ID slave.
// After a start request it reads word 0 (system ID) and then word 1 (build
// timestamp). It compares both against build-time expected values and
// publishes pass / fail / timeout status for boot logic.
//
// A read that stalls for TIMEOUT_CYCLES consecutive waitrequest cycles is
// abandoned. The check is then retried from the ID word, up to MAX_RETRIES
// times. A data mismatch is never retried.
//
// Optional feature (macro SYSID_CHECK_AUTOSTART_EN):
//   When the macro is defined, the first full cycle after reset release acts
//   as an internal start pulse. A check therefore runs once without software.
//   When the macro is undefined, the block waits in IDLE for start.
//
// Ports:
//   clock            in   system clock, all state on the rising edge
//   reset            in   asynchronous, active-high reset
//   start            in   one-cycle check request, ignored while busy
//   avm_address      out  0 = ID word, 1 = timestamp word
//   avm_read         out  Avalon read strobe
//   avm_waitrequest  in   slave stall
//   avm_readdata     in   read data, valid in the completing cycle
//   busy             out  check in progress
//   done             out  check finished, results valid (level)
//   pass             out  done and both words matched
//   id_ok            out  captured ID equals EXPECTED_ID
//   ts_ok            out  captured timestamp equals EXPECTED_TS
//   timeout          out  done because the retries were exhausted
//   captured_id      out  last ID word read
//   captured_ts      out  last timestamp word read
//   retry_count      out  timed-out attempts in the current check
// -----------------------------------------------------------------------------
module sysid_check_master #(
   parameter logic [31:0] EXPECTED_ID    = 32'd102,
   parameter logic [31:0] EXPECTED_TS    = 32'd1526570516,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts,
   output logic [7:0]  retry_count
);

   // The wait counter and retry_count are 8 bits wide. The limits are
   // clamped into that range so that an oversized parameter cannot wrap.
   localparam logic [7:0] TIMEOUT_LIMIT =
      (TIMEOUT_CYCLES > 255) ? 8'd255 :
      (TIMEOUT_CYCLES < 1)   ? 8'd1   : 8'(TIMEOUT_CYCLES);
   localparam logic [7:0] RETRY_LIMIT =
      (MAX_RETRIES > 255) ? 8'd255 :
      (MAX_RETRIES < 0)   ? 8'd0   : 8'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_RD_TS,
      S_COMPARE,
      S_RETRY,
      S_DONE
   } state_t;

   state_t      r_state;
   logic        r_avm_read;
   logic        r_avm_address;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic        r_id_ok;
   logic        r_ts_ok;
   logic        r_timeout;
   logic [31:0] r_captured_id;
   logic [31:0] r_captured_ts;
   logic [7:0]  r_retry_count;
   logic [7:0]  r_wait_cnt;

   state_t      w_nxt_state;
   logic        w_nxt_avm_read;
   logic        w_nxt_avm_address;
   logic        w_nxt_busy;
   logic        w_nxt_done;
   logic        w_nxt_pass;
   logic        w_nxt_id_ok;
   logic        w_nxt_ts_ok;
   logic        w_nxt_timeout;
   logic [31:0] w_nxt_captured_id;
   logic [31:0] w_nxt_captured_ts;
   logic [7:0]  w_nxt_retry_count;
   logic [7:0]  w_nxt_wait_cnt;

   logic        w_start;
   logic [7:0]  w_wait_inc;

`ifdef SYSID_CHECK_AUTOSTART_EN
   // r_auto_arm is 1 for the first clock after reset release. That clock
   // moves the arm flag into r_auto_start, so the internal start pulse is
   // seen during the first full cycle and is then gone for good.
   logic r_auto_arm;
   logic r_auto_start;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_auto_arm   <= 1'b1;
         r_auto_start <= 1'b0;
      end else begin
         r_auto_start <= r_auto_arm;
         r_auto_arm   <= 1'b0;
      end
   end

   assign w_start = start | r_auto_start;
`else
   assign w_start = start;
`endif

   // Saturating increment of the wait counter.
   assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

   // Next-state and next-output logic.
   // NOTE: every signal gets a hold-value default before the case. That way
   // no path through the block can leave a signal unassigned and infer a latch.
   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_avm_read    = r_avm_read;
      w_nxt_avm_address = r_avm_address;
      w_nxt_busy        = r_busy;
      w_nxt_done        = r_done;
      w_nxt_pass        = r_pass;
      w_nxt_id_ok       = r_id_ok;
      w_nxt_ts_ok       = r_ts_ok;
      w_nxt_timeout     = r_timeout;
      w_nxt_captured_id = r_captured_id;
      w_nxt_captured_ts = r_captured_ts;
      w_nxt_retry_count = r_retry_count;
      w_nxt_wait_cnt    = r_wait_cnt;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start) begin
               w_nxt_state       = S_RD_ID;
               w_nxt_avm_read    = 1'b1;
               w_nxt_avm_address = 1'b0;
               w_nxt_busy        = 1'b1;
               w_nxt_done        = 1'b0;
               w_nxt_pass        = 1'b0;
               w_nxt_id_ok       = 1'b0;
               w_nxt_ts_ok       = 1'b0;
               w_nxt_timeout     = 1'b0;
               w_nxt_retry_count = 8'd0;
               w_nxt_wait_cnt    = 8'd0;
            end
         end

         S_RD_ID, S_RD_TS: begin
            if (avm_waitrequest) begin
               if (w_wait_inc >= TIMEOUT_LIMIT) begin
                  // Abandon the stalled read. It is retried from the ID word,
                  // or the check ends with timeout once the retries are used up.
                  w_nxt_avm_read    = 1'b0;
                  w_nxt_avm_address = 1'b0;
                  w_nxt_wait_cnt    = 8'd0;
                  if (r_retry_count < RETRY_LIMIT) begin
                     w_nxt_retry_count = r_retry_count + 8'd1;
                     w_nxt_state       = S_RETRY;
                  end else begin
                     w_nxt_timeout = 1'b1;
                     w_nxt_pass    = 1'b0;
                     w_nxt_done    = 1'b1;
                     w_nxt_busy    = 1'b0;
                     w_nxt_state   = S_DONE;
                  end
               end else begin
                  // Address and read are held while the slave stalls.
                  w_nxt_wait_cnt = w_wait_inc;
               end
            end else if (r_state == S_RD_ID) begin
               // Back-to-back read: the strobe stays high and only the address moves.
               w_nxt_captured_id = avm_readdata;
               w_nxt_wait_cnt    = 8'd0;
               w_nxt_avm_address = 1'b1;
               w_nxt_state       = S_RD_TS;
            end else begin
               w_nxt_captured_ts = avm_readdata;
               w_nxt_wait_cnt    = 8'd0;
               w_nxt_avm_read    = 1'b0;
               w_nxt_avm_address = 1'b0;
               w_nxt_state       = S_COMPARE;
            end
         end

         S_COMPARE: begin
            w_nxt_id_ok = (r_captured_id == EXPECTED_ID);
            w_nxt_ts_ok = (r_captured_ts == EXPECTED_TS);
            w_nxt_pass  = (r_captured_id == EXPECTED_ID) &&
                          (r_captured_ts == EXPECTED_TS);
            w_nxt_done  = 1'b1;
            w_nxt_busy  = 1'b0;
            w_nxt_state = S_DONE;
         end

         S_RETRY: begin
            w_nxt_wait_cnt    = 8'd0;
            w_nxt_avm_read    = 1'b1;
            w_nxt_avm_address = 1'b0;
            w_nxt_state       = S_RD_ID;
         end

         default: begin
            w_nxt_state       = S_IDLE;
            w_nxt_avm_read    = 1'b0;
            w_nxt_avm_address = 1'b0;
            w_nxt_busy        = 1'b0;
         end
      endcase
   end

   // State register.
   // NOTE: sequential blocks use non-blocking assignments only. All registers
   // then update from the same pre-edge values, whatever the order of statements.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_nxt_state;
   end

   // Registered outputs and datapath. Reset clears the captured words too,
   // so no data from an interrupted read survives.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_avm_read    <= 1'b0;
         r_avm_address <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_id_ok       <= 1'b0;
         r_ts_ok       <= 1'b0;
         r_timeout     <= 1'b0;
         r_captured_id <= 32'd0;
         r_captured_ts <= 32'd0;
         r_retry_count <= 8'd0;
         r_wait_cnt    <= 8'd0;
      end else begin
         r_avm_read    <= w_nxt_avm_read;
         r_avm_address <= w_nxt_avm_address;
         r_busy        <= w_nxt_busy;
         r_done        <= w_nxt_done;
         r_pass        <= w_nxt_pass;
         r_id_ok       <= w_nxt_id_ok;
         r_ts_ok       <= w_nxt_ts_ok;
         r_timeout     <= w_nxt_timeout;
         r_captured_id <= w_nxt_captured_id;
         r_captured_ts <= w_nxt_captured_ts;
         r_retry_count <= w_nxt_retry_count;
         r_wait_cnt    <= w_nxt_wait_cnt;
      end
   end

   assign avm_read    = r_avm_read;
   assign avm_address = r_avm_address;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign id_ok       = r_id_ok;
   assign ts_ok       = r_ts_ok;
   assign timeout     = r_timeout;
   assign captured_id = r_captured_id;
   assign captured_ts = r_captured_ts;
   assign retry_count = r_retry_count;

endmodule

// File: tb/tb_sysid_check_master.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_master
//
// Directed bench for sysid_check_master. DUT "a" uses the default parameters
// and is served by a zero-latency sysid slave model. DUT "b" uses
// TIMEOUT_CYCLES=4 and MAX_RETRIES=2, and its slave holds waitrequest high.
// Cycle numbering: the start pulse is in cycle 0, and cycle k begins k rising
// edges later. Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_sysid_check_master;

   localparam logic [31:0] GOOD_ID = 32'd102;
   localparam logic [31:0] GOOD_TS = 32'd1526570516;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // DUT a
   logic        start_a = 1'b0;
   logic        waitreq_a = 1'b0;
   logic [31:0] id_val = GOOD_ID;
   logic [31:0] ts_val = GOOD_TS;
   logic        addr_a, read_a, busy_a, done_a, pass_a, id_ok_a, ts_ok_a, timeout_a;
   logic [31:0] readdata_a, cap_id_a, cap_ts_a;
   logic [7:0]  retry_a;

   assign readdata_a = addr_a ? ts_val : id_val;

   sysid_check_master dut_a (
      .clock           (clock),
      .reset           (reset),
      .start           (start_a),
      .avm_address     (addr_a),
      .avm_read        (read_a),
      .avm_waitrequest (waitreq_a),
      .avm_readdata    (readdata_a),
      .busy            (busy_a),
      .done            (done_a),
      .pass            (pass_a),
      .id_ok           (id_ok_a),
      .ts_ok           (ts_ok_a),
      .timeout         (timeout_a),
      .captured_id     (cap_id_a),
      .captured_ts     (cap_ts_a),
      .retry_count     (retry_a)
   );

   // DUT b
   logic        start_b = 1'b0;
   logic        waitreq_b = 1'b1;
   logic [31:0] readdata_b = 32'd0;
   logic        addr_b, read_b, busy_b, done_b, pass_b, id_ok_b, ts_ok_b, timeout_b;
   logic [31:0] cap_id_b, cap_ts_b;
   logic [7:0]  retry_b;

   sysid_check_master #(
      .TIMEOUT_CYCLES (4),
      .MAX_RETRIES    (2)
   ) dut_b (
      .clock           (clock),
      .reset           (reset),
      .start           (start_b),
      .avm_address     (addr_b),
      .avm_read        (read_b),
      .avm_waitrequest (waitreq_b),
      .avm_readdata    (readdata_b),
      .busy            (busy_b),
      .done            (done_b),
      .pass            (pass_b),
      .id_ok           (id_ok_b),
      .ts_ok           (ts_ok_b),
      .timeout         (timeout_b),
      .captured_id     (cap_id_b),
      .captured_ts     (cap_ts_b),
      .retry_count     (retry_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      n_checks++;
      if ({read_a, addr_a, busy_a, done_a, pass_a, id_ok_a, ts_ok_a, timeout_a} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, expected 00000000",
                  {read_a, addr_a, busy_a, done_a, pass_a, id_ok_a, ts_ok_a, timeout_a});
      end
      n_checks++;
      if ({cap_id_a, cap_ts_a, retry_a} !== 72'd0) begin
         n_fail++;
         $display("FAIL reset_data: got id=%0h ts=%0h retry=%0d, expected all 0", cap_id_a, cap_ts_a, retry_a);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_zero_wait();
      waitreq_a = 1'b0; id_val = GOOD_ID; ts_val = GOOD_TS;
      start_a = 1'b1;
      step();                          // cycle 1
      start_a = 1'b0;
      n_checks++;
      if ({read_a, addr_a, busy_a} !== 3'b101) begin
         n_fail++;
         $display("FAIL zw_cycle1_rd_id: got read,addr,busy=%b, expected 101", {read_a, addr_a, busy_a});
      end
      step();                          // cycle 2
      n_checks++;
      if ({read_a, addr_a} !== 2'b11) begin
         n_fail++;
         $display("FAIL zw_cycle2_rd_ts: got read,addr=%b, expected 11", {read_a, addr_a});
      end
      step();                          // cycle 3
      n_checks++;
      if ({read_a, busy_a, done_a} !== 3'b010) begin
         n_fail++;
         $display("FAIL zw_cycle3_compare: got read,busy,done=%b, expected 010", {read_a, busy_a, done_a});
      end
      step();                          // cycle 4
      n_checks++;
      if ({done_a, pass_a, id_ok_a, ts_ok_a, busy_a, timeout_a} !== 6'b111100) begin
         n_fail++;
         $display("FAIL zw_cycle4_done: got done,pass,id_ok,ts_ok,busy,timeout=%b, expected 111100",
                  {done_a, pass_a, id_ok_a, ts_ok_a, busy_a, timeout_a});
      end
      n_checks++;
      if ({cap_id_a, cap_ts_a, retry_a} !== {GOOD_ID, GOOD_TS, 8'd0}) begin
         n_fail++;
         $display("FAIL zw_captured: got id=%0d ts=%0d retry=%0d, expected 102 1526570516 0", cap_id_a, cap_ts_a, retry_a);
      end
   endtask

   task automatic test_mismatch();
      id_val = 32'd103;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      step(); step(); step();          // cycle 4
      n_checks++;
      if ({done_a, pass_a, id_ok_a, ts_ok_a, timeout_a} !== 5'b10010) begin
         n_fail++;
         $display("FAIL mm_status: got done,pass,id_ok,ts_ok,timeout=%b, expected 10010",
                  {done_a, pass_a, id_ok_a, ts_ok_a, timeout_a});
      end
      n_checks++;
      if ({cap_id_a, retry_a} !== {32'd103, 8'd0}) begin
         n_fail++;
         $display("FAIL mm_captured: got id=%0d retry=%0d, expected 103 0", cap_id_a, retry_a);
      end
      step(); step();
      n_checks++;
      if ({read_a, busy_a, done_a} !== 3'b001) begin
         n_fail++;
         $display("FAIL mm_no_retry: got read,busy,done=%b, expected 001", {read_a, busy_a, done_a});
      end
      id_val = GOOD_ID;
   endtask

   task automatic test_stall();
      waitreq_a = 1'b1;
      start_a = 1'b1;
      step();                          // cycle 1
      start_a = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         n_checks++;
         if ({read_a, addr_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL st_id_hold c%0d: got read,addr=%b, expected 10", c, {read_a, addr_a});
         end
         step();
      end
      waitreq_a = 1'b0;                // cycle 11: ID completes
      step();                          // cycle 12
      waitreq_a = 1'b1;
      for (int c = 12; c <= 21; c++) begin
         n_checks++;
         if ({read_a, addr_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL st_ts_hold c%0d: got read,addr=%b, expected 11", c, {read_a, addr_a});
         end
         step();
      end
      waitreq_a = 1'b0;                // cycle 22: timestamp completes
      step();                          // cycle 23
      n_checks++;
      if (done_a !== 1'b0) begin
         n_fail++;
         $display("FAIL st_c23_not_done: got done=%b, expected 0", done_a);
      end
      step();                          // cycle 24
      n_checks++;
      if ({done_a, pass_a, retry_a} !== {1'b1, 1'b1, 8'd0}) begin
         n_fail++;
         $display("FAIL st_c24_done: got done=%b pass=%b retry=%0d, expected 1 1 0", done_a, pass_a, retry_a);
      end
   endtask

   task automatic test_timeout();
      logic exp_read;
      waitreq_b = 1'b1;
      start_b = 1'b1;
      step();                          // cycle 1
      start_b = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         exp_read = (c != 5) && (c != 10);
         n_checks++;
         if (read_b !== exp_read) begin
            n_fail++;
            $display("FAIL to_read c%0d: got read=%b, expected %b", c, read_b, exp_read);
         end
         if (c == 5 || c == 10) begin
            n_checks++;
            if (retry_b !== ((c == 5) ? 8'd1 : 8'd2)) begin
               n_fail++;
               $display("FAIL to_retry c%0d: got retry=%0d, expected %0d", c, retry_b, (c == 5) ? 1 : 2);
            end
         end
         if (c == 14) begin
            n_checks++;
            if (done_b !== 1'b0) begin
               n_fail++;
               $display("FAIL to_c14_not_done: got done=%b, expected 0", done_b);
            end
         end
         step();
      end
      n_checks++;                      // cycle 15
      if ({done_b, timeout_b, pass_b, busy_b, read_b, retry_b} !== {5'b11000, 8'd2}) begin
         n_fail++;
         $display("FAIL to_final: got done,timeout,pass,busy,read=%b retry=%0d, expected 11000 2",
                  {done_b, timeout_b, pass_b, busy_b, read_b}, retry_b);
      end
   endtask

   task automatic test_back_to_back();
      waitreq_a = 1'b0; id_val = 32'd103;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      step(); step();                  // cycle 3: COMPARE
      start_a = 1'b1;
      step();                          // cycle 4
      start_a = 1'b0;
      step();                          // cycle 5
      n_checks++;
      if ({done_a, pass_a, busy_a, read_a} !== 4'b1000) begin
         n_fail++;
         $display("FAIL bb_compare_start_ignored: got done,pass,busy,read=%b, expected 1000",
                  {done_a, pass_a, busy_a, read_a});
      end
      id_val = GOOD_ID;
      start_a = 1'b1;
      step();                          // cycle 1 of the restart
      start_a = 1'b0;
      n_checks++;
      if ({done_a, pass_a, id_ok_a, ts_ok_a, busy_a} !== 5'b00001) begin
         n_fail++;
         $display("FAIL bb_restart_clear: got done,pass,id_ok,ts_ok,busy=%b, expected 00001",
                  {done_a, pass_a, id_ok_a, ts_ok_a, busy_a});
      end
      step(); step(); step();          // cycle 4
      n_checks++;
      if ({done_a, pass_a} !== 2'b11) begin
         n_fail++;
         $display("FAIL bb_restart_pass: got done,pass=%b, expected 11", {done_a, pass_a});
      end
   endtask

   task automatic test_start_busy_and_reset();
      waitreq_a = 1'b0;
      start_a = 1'b1;
      step();                          // cycle 1: ID completes
      start_a = 1'b0;
      step();                          // cycle 2: RD_TS, stalled
      waitreq_a = 1'b1;
      start_a = 1'b1;
      step();                          // cycle 3
      start_a = 1'b0;
      n_checks++;
      if ({read_a, addr_a, busy_a, done_a} !== 4'b1110) begin
         n_fail++;
         $display("FAIL sr_busy_start_ignored: got read,addr,busy,done=%b, expected 1110",
                  {read_a, addr_a, busy_a, done_a});
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({read_a, addr_a, busy_a, done_a, pass_a, timeout_a} !== 6'b000000) begin
         n_fail++;
         $display("FAIL sr_async_reset_flags: got read,addr,busy,done,pass,timeout=%b, expected 000000",
                  {read_a, addr_a, busy_a, done_a, pass_a, timeout_a});
      end
      n_checks++;
      if ({cap_id_a, cap_ts_a, retry_a} !== 72'd0) begin
         n_fail++;
         $display("FAIL sr_async_reset_data: got id=%0h ts=%0h retry=%0d, expected all 0", cap_id_a, cap_ts_a, retry_a);
      end
      @(negedge clock);
      reset = 1'b0;
      waitreq_a = 1'b0;
      step(); step();
      n_checks++;
      if ({busy_a, read_a} !== 2'b00) begin
         n_fail++;
         $display("FAIL sr_idle_after_reset: got busy,read=%b, expected 00", {busy_a, read_a});
      end
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      step(); step(); step();
      n_checks++;
      if ({done_a, pass_a, cap_id_a} !== {2'b11, GOOD_ID}) begin
         n_fail++;
         $display("FAIL sr_post_reset_pass: got done,pass=%b id=%0d, expected 11 102", {done_a, pass_a}, cap_id_a);
      end
   endtask

`ifdef SYSID_CHECK_AUTOSTART_EN
   task automatic test_autostart();
      // Reset was released at a falling edge. The next rising edge is E0.
      waitreq_a = 1'b0;
      step();                          // after E0
      step();                          // after E1
      n_checks++;
      if ({busy_a, read_a} !== 2'b11) begin
         n_fail++;
         $display("FAIL as_running: got busy,read=%b, expected 11", {busy_a, read_a});
      end
      step(); step();                  // after E3
      n_checks++;
      if (done_a !== 1'b0) begin
         n_fail++;
         $display("FAIL as_e3_not_done: got done=%b, expected 0", done_a);
      end
      step();                          // after E4
      n_checks++;
      if ({done_a, pass_a} !== 2'b11) begin
         n_fail++;
         $display("FAIL as_e4_done: got done,pass=%b, expected 11", {done_a, pass_a});
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef SYSID_CHECK_AUTOSTART_EN
      test_autostart();
`else
      step();
      test_zero_wait();
      test_mismatch();
      test_stall();
      test_timeout();
      test_back_to_back();
      test_start_busy_and_reset();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
